// File: rtl/ddr2_rd_responder_if.sv
// Pin-level DDR2 command bus between the PHY (master) and the DRAM read responder (slave).
interface ddr2_rd_responder_if #(
  parameter int CS_WIDTH   = 1,
  parameter int BA_WIDTH   = 3,
  parameter int ADDR_WIDTH = 14
);
  logic                  cke;
  logic [CS_WIDTH-1:0]   cs_n;
  logic                  ras_n;
  logic                  cas_n;
  logic                  we_n;
  logic [BA_WIDTH-1:0]   ba;
  logic [ADDR_WIDTH-1:0] addr;

  modport master (output cke, cs_n, ras_n, cas_n, we_n, ba, addr);
  modport slave  (input  cke, cs_n, ras_n, cas_n, we_n, ba, addr);
endinterface

// File: rtl/ddr2_rd_responder.sv
// DDR2 read-side DRAM responder: tracks open rows and answers each accepted READ
// with a deterministic DQS-framed burst CL cycles later.
//
// state | meaning
// IDLE  | dq/dqs/dqs_n released (Z)
// PRE   | read preamble: dqs low, dqs_n high, dq Z
// DATA  | dqs follows clk, dq carries beat 2k (clk high) / 2k+1 (clk low)
module ddr2_rd_responder #(
  parameter int BA_WIDTH   = 3,
  parameter int ADDR_WIDTH = 14,
  parameter int CS_WIDTH   = 1,
  parameter int CL         = 5,
  parameter int BL         = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  ddr2_rd_responder_if.slave  cmd,
  inout  wire  [63:0]         dq,
  inout  wire  [7:0]          dqs,
  inout  wire  [7:0]          dqs_n,
  output logic                err,
  output logic [15:0]         rd_seq
);

  localparam int NB    = 1 << BA_WIDTH;
  localparam int BURST = BL / 2;
  localparam int DEPTH = CL + BURST;
  localparam int TAG_W = BA_WIDTH + 2 * ADDR_WIDTH + 16;

  typedef enum logic [1:0] {IDLE, PRE, DATA} drv_state_e;

  logic [NB-1:0]         bank_open;
  logic [ADDR_WIDTH-1:0] bank_row [NB];
  logic [2:0]            gap_cnt;
  logic [DEPTH-1:0]      pipe_vld;
  logic [DEPTH-1:0]      nxt_vld;
  logic [TAG_W-1:0]      pipe_tag [DEPTH];
  logic [TAG_W-1:0]      nxt_tag  [DEPTH];

  drv_state_e            state_q, state_d;
  logic [1:0]            k_q, k_d;
  logic [TAG_W-1:0]      tag_q, tag_d;

  logic                  cmd_vld, is_act, is_rd, is_pre;
  logic                  act_bad, rd_bad, rd_ok;
  logic [ADDR_WIDTH-1:0] rd_col;
  logic [TAG_W-1:0]      new_tag;

  assign cmd_vld = cmd.cke && !cmd.cs_n[0];
  assign is_act  = cmd_vld && ({cmd.ras_n, cmd.cas_n, cmd.we_n} == 3'b011);
  assign is_rd   = cmd_vld && ({cmd.ras_n, cmd.cas_n, cmd.we_n} == 3'b101);
  assign is_pre  = cmd_vld && ({cmd.ras_n, cmd.cas_n, cmd.we_n} == 3'b010);

  // Closed bank and spacing violations fold into one error pulse.
  assign act_bad = is_act && bank_open[cmd.ba];
  assign rd_bad  = is_rd && (!bank_open[cmd.ba] || (gap_cnt != 3'd0));
  assign rd_ok   = is_rd && !rd_bad;

  always_comb begin
    rd_col     = cmd.addr;
    rd_col[10] = 1'b0;
  end

  assign new_tag = {cmd.ba, bank_row[cmd.ba], rd_col, rd_seq};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_open <= '0;
      gap_cnt   <= 3'd0;
      pipe_vld  <= '0;
      rd_seq    <= 16'd0;
      err       <= 1'b0;
    end else begin
      err      <= act_bad || rd_bad;
      pipe_vld <= nxt_vld;
      if (gap_cnt != 3'd0) gap_cnt <= gap_cnt - 3'd1;
      if (is_act) bank_open[cmd.ba] <= 1'b1;
      if (is_pre) begin
        if (cmd.addr[10]) bank_open <= '0;
        else              bank_open[cmd.ba] <= 1'b0;
      end
      if (rd_ok) begin
        rd_seq  <= rd_seq + 16'd1;
        gap_cnt <= 3'(BURST - 1);
        if (cmd.addr[10]) bank_open[cmd.ba] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (is_act) bank_row[cmd.ba] <= cmd.addr;
    pipe_tag <= nxt_tag;
  end

  // Schedule shift register: an entry at index i was accepted i cycles ago.
  always_comb begin
    nxt_vld    = {pipe_vld[DEPTH-2:0], rd_ok};
    nxt_tag[0] = new_tag;
    for (int i = 1; i < DEPTH; i++) nxt_tag[i] = pipe_tag[i-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      tag_q   <= tag_d;
    end
  end

  // DATA of an earlier burst wins over the preamble of the next: seamless reads.
  always_comb begin
    state_d = IDLE;
    k_d     = 2'd0;
    tag_d   = '0;
    for (int i = CL; i < DEPTH; i++) begin
      if (nxt_vld[i]) begin
        state_d = DATA;
        k_d     = 2'(i - CL);
        tag_d   = nxt_tag[i];
      end
    end
    if (state_d != DATA && nxt_vld[CL-1]) state_d = PRE;
  end

  logic [BA_WIDTH-1:0]   t_ba;
  logic [ADDR_WIDTH-1:0] t_row, t_col;
  logic [15:0]           t_seq;
  logic [2:0]            beat_j;
  logic [63:0]           beat;

  assign t_ba   = tag_q[TAG_W-1 -: BA_WIDTH];
  assign t_row  = tag_q[2*ADDR_WIDTH+15 -: ADDR_WIDTH];
  assign t_col  = tag_q[ADDR_WIDTH+15 -: ADDR_WIDTH];
  assign t_seq  = tag_q[15:0];
  assign beat_j = {k_q, ~clk};
  assign beat   = {8'hD0 | {5'd0, beat_j}, 8'(t_ba), 16'(t_row), 16'(t_col), t_seq};

  assign dq    = (state_q == DATA) ? beat : 64'bz;
  assign dqs   = (state_q == DATA) ? {8{clk}}  : (state_q == PRE) ? 8'h00 : 8'bz;
  assign dqs_n = (state_q == DATA) ? {8{~clk}} : (state_q == PRE) ? 8'hFF : 8'bz;

endmodule
